// File: rtl/m_of_n_pkg.sv
// Shared types, 7-seg font and combinatorial helpers for the M-of-N scan decoder.
// The helpers fold to constants / plain muxes once N and M are fixed.
package m_of_n_pkg;

  typedef struct packed {
    logic       vld;
    logic [3:0] rank;
  } hist_entry_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;

  // {G,F,E,D,C,B,A} hex font
  localparam logic [6:0] SEG_FONT [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int binom(input int n, input int k);
    int r;
    if (k < 0 || k > n) return 0;
    r = 1;
    for (int i = 1; i <= k; i++) r = r * (n - k + i) / i;
    return r;
  endfunction

  // Colex rank: the i-th set bit (ascending) at position p contributes C(p,i).
  // binom() only ever sees loop constants, so no arithmetic survives synthesis.
  function automatic int colex_rank(input logic [31:0] code, input int n, input int m);
    int r;
    int ones;
    r    = 0;
    ones = 0;
    for (int p = 0; p < n; p++) begin
      if (code[p[4:0]]) begin
        ones++;
        for (int j = 1; j <= m; j++)
          if (ones == j) r += binom(p, j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/m_of_n_scan_decoder_debouncer.sv
// Two-flop synchroniser plus stability counter; commits a code that has been
// stable DEB_CYC cycles and differs from the last committed one.
module code_debouncer #(
  parameter int W       = 5,
  parameter int DEB_CYC = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] code,
  output logic         commit
);

  localparam int CW = $clog2(DEB_CYC + 1);

  logic [W-1:0]  sync1, sync2;
  logic [CW-1:0] cnt;
  logic          stable;

  assign stable = (cnt == CW'(DEB_CYC));

  // cnt = cycles sync2 has held its present value (saturating)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      cnt    <= '0;
      code   <= '0;
      commit <= 1'b0;
    end else begin
      sync1  <= din;
      sync2  <= sync1;
      if (sync1 != sync2)  cnt <= CW'(1);
      else if (!stable)    cnt <= cnt + CW'(1);
      commit <= 1'b0;
      if (stable && (sync2 != code)) begin
        code   <= sync2;
        commit <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/m_of_n_scan_decoder.sv
// M-of-N switch code validator: debounce, validate, colex-decode, digit history
// and a time-multiplexed 7-seg scan with an error dash override.
module m_of_n_scan_decoder
  import m_of_n_pkg::*;
#(
  parameter int N        = 5,
  parameter int M        = 2,
  parameter int DIGITS   = 3,
  parameter int DEB_CYC  = 16,
  parameter int SCAN_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      code_in,
  input  logic              clr,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] dig_sel,
  output logic [N-1:0]      col,
  output logic              valid,
  output logic              err,
  output logic [7:0]        err_cnt,
  output logic              commit
);

  if (binom(N, M) > 16) begin : g_bad_code_space
    $error("m_of_n_scan_decoder: C(N,M) exceeds 16 digit values");
  end
  if (DIGITS < 1 || DEB_CYC < 2 || SCAN_DIV < 1) begin : g_bad_params
    $error("m_of_n_scan_decoder: DIGITS>=1, DEB_CYC>=2, SCAN_DIV>=1 required");
  end

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [N-1:0] code;
  logic [3:0]   rank;

  code_debouncer #(.W(N), .DEB_CYC(DEB_CYC)) u_deb (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (code_in),
    .code   (code),
    .commit (commit)
  );

  // code and commit are both registers, so valid/col change in the commit cycle
  assign valid = ($countones(code) == M);
  assign col   = code & {N{valid}};
  assign rank  = 4'(colex_rank(32'(code), N, M));

  hist_entry_t [DIGITS-1:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist    <= '0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (clr) begin
      hist    <= '0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (commit) begin
      if (valid) begin
        for (int k = DIGITS - 1; k > 0; k--) hist[k] <= hist[k-1];
        hist[0] <= '{vld: 1'b1, rank: rank};
      end else begin
        err <= 1'b1;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  // Scan: prescaler wrap advances the one-hot digit; seg is built from the
  // next dig_sel so both registers land on the same edge.
  logic [PW-1:0]     pre;
  logic              wrap;
  logic [DIGITS-1:0] dig_rot, dig_nxt;
  logic [6:0]        seg_nxt;

  assign wrap = (pre == PW'(SCAN_DIV - 1));

  always_comb begin
    dig_rot = '0;
    for (int k = 0; k < DIGITS; k++) dig_rot[(k + 1) % DIGITS] = dig_sel[k];
    dig_nxt = wrap ? dig_rot : dig_sel;
    seg_nxt = SEG_BLANK;
    for (int k = 0; k < DIGITS; k++)
      if (dig_nxt[k] && hist[k].vld) seg_nxt = SEG_FONT[hist[k].rank];
    if (err) seg_nxt = SEG_DASH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre     <= '0;
      dig_sel <= DIGITS'(1);
      seg     <= SEG_BLANK;
    end else begin
      pre     <= wrap ? '0 : pre + PW'(1);
      dig_sel <= dig_nxt;
      seg     <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_m_of_n_scan_decoder.sv
// Table-driven bench with a commit scoreboard for m_of_n_scan_decoder
// (N=5, M=2, 3 digits, short debounce and scan periods).
module tb_m_of_n_scan_decoder;

  localparam int N        = 5;
  localparam int M        = 2;
  localparam int DIGITS   = 3;
  localparam int DEB_CYC  = 4;
  localparam int SCAN_DIV = 3;
  localparam int LAT      = DEB_CYC + 2;

  localparam logic [6:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  localparam logic [6:0] DASH = 7'b1000000;

  typedef struct {
    logic [N-1:0] code;
    logic         exp_valid;
    logic [N-1:0] exp_col;
    int           exp_rank;
  } vec_t;

  typedef struct {
    logic         valid;
    logic [N-1:0] col;
  } sb_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clr = 1'b0;
  logic [N-1:0]      code_in = '0;
  logic [6:0]        seg;
  logic [DIGITS-1:0] dig_sel;
  logic [N-1:0]      col;
  logic              valid, err, commit;
  logic [7:0]        err_cnt;

  int   n_chk = 0;
  int   n_fail = 0;
  sb_t  sb[$];
  sb_t  mon_e;
  int   hist_m [DIGITS];
  int   err_m = 0;
  int   errc_m = 0;
  vec_t tv [5];

  m_of_n_scan_decoder #(
    .N(N), .M(M), .DIGITS(DIGITS), .DEB_CYC(DEB_CYC), .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .code_in(code_in), .clr(clr),
    .seg(seg), .dig_sel(dig_sel), .col(col), .valid(valid),
    .err(err), .err_cnt(err_cnt), .commit(commit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every commit pulse must match the oldest expected code
  always @(negedge clk) begin
    if (rst_n === 1'b1 && commit === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_commit", {27'd0, col}, 32'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        chk("commit_valid", {31'd0, valid}, {31'd0, mon_e.valid});
        chk("commit_col", {27'd0, col}, {27'd0, mon_e.col});
      end
    end
  end

  task automatic drive_code(input logic [N-1:0] c);
    @(posedge clk);
    #1 code_in = c;
  endtask

  task automatic wait_commit(input string name, input int exp_lat);
    int lat;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (commit === 1'b1) begin
        lat = c;
        break;
      end
    end
    chk(name, lat, exp_lat);
  endtask

  task automatic hist_push(input int r);
    for (int k = DIGITS - 1; k > 0; k--) hist_m[k] = hist_m[k-1];
    hist_m[0] = r;
  endtask

  task automatic hist_blank();
    for (int k = 0; k < DIGITS; k++) hist_m[k] = -1;
  endtask

  task automatic check_display(input string tag);
    logic [6:0] exp;
    int found;
    for (int k = 0; k < DIGITS; k++) begin
      found = 0;
      for (int t = 0; t < SCAN_DIV * DIGITS + 4; t++) begin
        @(negedge clk);
        if (dig_sel === DIGITS'(1 << k)) begin
          found = 1;
          break;
        end
      end
      chk($sformatf("%s_slot%0d_reached", tag, k), found, 1);
      if (err_m != 0)        exp = DASH;
      else if (hist_m[k] < 0) exp = 7'h00;
      else                   exp = FONT[hist_m[k]];
      chk($sformatf("%s_seg%0d", tag, k), {25'd0, seg}, {25'd0, exp});
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_seg"}, {25'd0, seg}, 32'd0);
    chk({tag, "_dig_sel"}, {29'd0, dig_sel}, 32'd1);
    chk({tag, "_col"}, {27'd0, col}, 32'd0);
    chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_err_cnt"}, {24'd0, err_cnt}, 32'd0);
    chk({tag, "_commit"}, {31'd0, commit}, 32'd0);
  endtask

  initial begin
    logic [DIGITS-1:0] prev;
    int per;

    tv[0] = '{5'b00101, 1'b1, 5'b00101, 1};
    tv[1] = '{5'b00011, 1'b1, 5'b00011, 0};
    tv[2] = '{5'b01100, 1'b1, 5'b01100, 5};
    tv[3] = '{5'b11000, 1'b1, 5'b11000, 9};
    tv[4] = '{5'b00111, 1'b0, 5'b00000, -1};
    hist_blank();

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // scan timing: slot length and one-hot rotation direction
    prev = dig_sel;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (dig_sel !== prev) break;
    end
    prev = dig_sel;
    per = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      per++;
      if (dig_sel !== prev) break;
    end
    chk("scan_period", per, SCAN_DIV);
    chk("scan_rotate", {29'd0, dig_sel}, {29'd0, prev[1:0], prev[2]});

    // table: valid codes build history {9,5,0}, then an invalid code
    for (int i = 0; i < 5; i++) begin
      drive_code(tv[i].code);
      sb.push_back('{tv[i].exp_valid, tv[i].exp_col});
      wait_commit($sformatf("latency_tv%0d", i), LAT);
      if (tv[i].exp_valid) hist_push(tv[i].exp_rank);
      else begin
        err_m = 1;
        errc_m = (errc_m < 255) ? errc_m + 1 : 255;
      end
      repeat (2) @(negedge clk);
      chk($sformatf("err_tv%0d", i), {31'd0, err}, err_m);
      chk($sformatf("err_cnt_tv%0d", i), {24'd0, err_cnt}, errc_m);
      check_display($sformatf("disp_tv%0d", i));
    end

    // glitch on bit0 during the count: only the final stable code commits
    drive_code(5'b01001);
    repeat (2) @(posedge clk);
    for (int g = 0; g < 4; g++) begin
      @(posedge clk);
      #1 code_in = code_in ^ 5'b00001;
    end
    sb.push_back('{1'b1, 5'b01001});
    wait_commit("latency_glitch", LAT);
    hist_push(3);

    // err_cnt saturation over 256 further invalid commits
    for (int i = 0; i < 256; i++) begin
      drive_code((i % 2 == 0) ? 5'b01110 : 5'b00111);
      sb.push_back('{1'b0, 5'b00000});
      wait_commit("latency_invalid", LAT);
      errc_m = (errc_m < 255) ? errc_m + 1 : 255;
      @(negedge clk);
      chk("err_cnt_sat", {24'd0, err_cnt}, errc_m);
    end
    check_display("disp_err");

    // clr in the commit cycle wins over the history shift
    drive_code(5'b00011);
    sb.push_back('{1'b1, 5'b00011});
    repeat (LAT) @(posedge clk);
    #1 clr = 1'b1;
    @(negedge clk);
    chk("clr_commit", {31'd0, commit}, 32'd1);
    chk("clr_valid", {31'd0, valid}, 32'd1);
    @(posedge clk);
    #1 clr = 1'b0;
    repeat (2) @(negedge clk);
    err_m = 0;
    errc_m = 0;
    hist_blank();
    chk("clr_err", {31'd0, err}, 32'd0);
    chk("clr_err_cnt", {24'd0, err_cnt}, 32'd0);
    check_display("disp_clr");

    // reset mid-debounce / mid-scan, then recovery re-commits the held code
    drive_code(5'b01010);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    reset_checks("midrst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    sb.push_back('{1'b1, 5'b01010});
    wait_commit("latency_after_reset", LAT);
    hist_push(4);
    repeat (2) @(negedge clk);
    check_display("disp_after_reset");

    // held code must not re-commit
    repeat (40) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
